// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART RX byte stream into registered control
// pulses, a saturating decimal-argument channel ("v<digits><CR|LF>") and
// ACK/NAK response bytes queued through a one-entry buffer to the TX FIFO.
module uart_cmd_parser #(
  parameter int ARG_W       = 16,
  parameter int MAX_DIGITS  = 5,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int RESP_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  output logic             o_run,
  output logic             o_stop,
  output logic             o_clear,
  output logic             o_mode,
  output logic [ARG_W-1:0] o_arg,
  output logic             o_arg_valid,
  output logic             o_err,
  output logic             o_busy,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_push,
  input  logic             i_tx_full
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      CNT_MAX = 4'(MAX_DIGITS);

  localparam logic [7:0] CH_R   = 8'h72;
  localparam logic [7:0] CH_S   = 8'h73;
  localparam logic [7:0] CH_C   = 8'h63;
  localparam logic [7:0] CH_M   = 8'h6D;
  localparam logic [7:0] CH_V   = 8'h76;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_NG = 8'h3F;

  typedef enum logic {S_IDLE = 1'b0, S_ARG = 1'b1} state_t;

  // acc*10 + d evaluated 4 bits wider than the argument, clamped to all-ones
  function automatic logic [ARG_W-1:0] sat_mac10(input logic [ARG_W-1:0] a,
                                                 input logic [3:0]       d);
    logic [ARG_W+3:0] w;
    w = ({4'd0, a} << 3) + ({4'd0, a} << 1) + {{ARG_W{1'b0}}, d};
    if (w > {4'd0, {ARG_W{1'b1}}}) return '1;
    return w[ARG_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [ARG_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic             buf_full_q, buf_full_d;
  logic [7:0]       buf_q, buf_d;
  logic [7:0]       txd_q, txd_d;
  logic             run_q, run_d, stop_q, stop_d, clear_q, clear_d, mode_q, mode_d;
  logic             argv_q, argv_d, err_q, err_d, busy_q, push_q, push_d;

  logic             perr, resp_v, drain, load_ok, drop, is_digit;
  logic [7:0]       resp_b;

  assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);

  // Byte decode, argument accumulation, timeout and response-buffer next state
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    arg_d   = arg_q;
    run_d   = 1'b0;
    stop_d  = 1'b0;
    clear_d = 1'b0;
    mode_d  = 1'b0;
    argv_d  = 1'b0;
    perr    = 1'b0;
    resp_v  = 1'b0;
    resp_b  = RSP_OK;

    case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CH_R: begin run_d   = 1'b1; resp_v = 1'b1; end
            CH_S: begin stop_d  = 1'b1; resp_v = 1'b1; end
            CH_C: begin clear_d = 1'b1; resp_v = 1'b1; end
            CH_M: begin mode_d  = 1'b1; resp_v = 1'b1; end
            CH_V: begin
              state_d = S_ARG;
              acc_d   = '0;
              cnt_d   = '0;
              to_d    = '0;
            end
            CH_CR, CH_LF, CH_SP: ;
            default: begin perr = 1'b1; resp_v = 1'b1; resp_b = RSP_NG; end
          endcase
        end
      end
      default: begin
        if (i_rx_done) begin
          to_d = '0;
          if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              perr = 1'b1; resp_v = 1'b1; resp_b = RSP_NG; state_d = S_IDLE;
            end else begin
              acc_d = sat_mac10(acc_q, i_rx_data[3:0]);
              cnt_d = cnt_q + 4'd1;
            end
          end else if ((i_rx_data == CH_CR) || (i_rx_data == CH_LF)) begin
            state_d = S_IDLE;
            resp_v  = 1'b1;
            if (cnt_q != 4'd0) begin
              arg_d  = acc_q;
              argv_d = 1'b1;
            end else begin
              perr   = 1'b1;
              resp_b = RSP_NG;
            end
          end else begin
            perr = 1'b1; resp_v = 1'b1; resp_b = RSP_NG; state_d = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          perr = 1'b1; resp_v = 1'b1; resp_b = RSP_NG;
          state_d = S_IDLE;
          acc_d   = '0;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
    endcase

    // Buffer may be refilled in the same cycle it drains, so only a held byte blocks
    drain      = buf_full_q && !i_tx_full;
    load_ok    = resp_v && (RESP_EN != 0) && (!buf_full_q || drain);
    drop       = resp_v && (RESP_EN != 0) && buf_full_q && !drain;
    buf_full_d = load_ok || (buf_full_q && !drain);
    buf_d      = load_ok ? resp_b : buf_q;
    push_d     = drain;
    txd_d      = drain ? buf_q : txd_q;
    err_d      = perr || drop;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      arg_q      <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      txd_q      <= '0;
      run_q      <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      mode_q     <= 1'b0;
      argv_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      arg_q      <= arg_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      txd_q      <= txd_d;
      run_q      <= run_d;
      stop_q     <= stop_d;
      clear_q    <= clear_d;
      mode_q     <= mode_d;
      argv_q     <= argv_d;
      err_q      <= err_d;
      busy_q     <= (state_d == S_ARG);
      push_q     <= push_d;
    end
  end

  assign o_run       = run_q;
  assign o_stop      = stop_q;
  assign o_clear     = clear_q;
  assign o_mode      = mode_q;
  assign o_arg       = arg_q;
  assign o_arg_valid = argv_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_tx_data   = txd_q;
  assign o_tx_push   = push_q;

endmodule
